// File: rtl/sprite_rom_arbiter.sv
// Sprite ROM arbiter: round-robin with bounded bursts across N_REQ sprite
// layers sharing one single-port ROM. Read data returns tagged with the
// requester ID a fixed ROM_LAT cycles after the ROM read is issued.
module sprite_rom_arbiter #(
   parameter int unsigned N_REQ     = 3,
   parameter int unsigned ADDR_W    = 12,
   parameter int unsigned DATA_W    = 4,
   parameter int unsigned ROM_LAT   = 1,
   parameter int unsigned MAX_BURST = 4,
   localparam int unsigned ID_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                     vga_clk,
   input  logic                     reset_n,
   input  logic [N_REQ-1:0]         req,
   input  logic [N_REQ*ADDR_W-1:0]  req_addr,
   output logic [N_REQ-1:0]         gnt,
   output logic                     rom_en,
   output logic [ADDR_W-1:0]        rom_addr,
   input  logic [DATA_W-1:0]        rom_q,
   output logic                     rd_valid,
   output logic [ID_W-1:0]          rd_id,
   output logic [DATA_W-1:0]        rd_data,
   output logic                     busy
);

   localparam int unsigned CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST - 1);

   logic [ID_W-1:0]   r_last;
   logic [ID_W-1:0]   r_owner;
   logic              r_owner_valid;
   logic [CNT_W-1:0]  r_burst_cnt;
   logic              r_rom_en;
   logic [ADDR_W-1:0] r_rom_addr;
   logic [ID_W-1:0]   r_rom_id;
   logic [ROM_LAT-1:0] r_pipe_v;
   logic [ID_W-1:0]   r_pipe_id [ROM_LAT];

   logic              w_owner_req;
   logic              w_others;
   logic              w_keep;
   logic              w_found;
   logic [ID_W-1:0]   w_scan_sel;
   logic [ID_W-1:0]   w_sel;
   logic              w_any;
   logic [N_REQ-1:0]  w_gnt;
   logic [ADDR_W-1:0] w_addr;

   // Arbitration: keep the burst owner while allowed, else rotate from last+1
   always_comb begin
      w_owner_req = 1'b0;
      w_others    = 1'b0;
      w_found     = 1'b0;
      w_scan_sel  = '0;
      w_gnt       = '0;
      w_addr      = '0;
      for (int unsigned j = 0; j < N_REQ; j++) begin
         if (ID_W'(j) == r_owner) begin
            w_owner_req = req[j];
         end else if (req[j]) begin
            w_others = 1'b1;
         end
      end
      for (int unsigned i = 0; i < N_REQ; i++) begin
         for (int unsigned j = 0; j < N_REQ; j++) begin
            if (!w_found && req[j] && (j == (32'(r_last) + i + 32'd1) % N_REQ)) begin
               w_found    = 1'b1;
               w_scan_sel = ID_W'(j);
            end
         end
      end
      w_keep = r_owner_valid && w_owner_req && ((r_burst_cnt < BURST_MAX) || !w_others);
      w_sel  = w_keep ? r_owner : w_scan_sel;
      // Gate with reset so no grant is advertised while the block is held in reset
      w_any  = (w_keep || w_found) && reset_n;
      for (int unsigned j = 0; j < N_REQ; j++) begin
         if (w_any && (ID_W'(j) == w_sel)) begin
            w_gnt[j] = 1'b1;
            w_addr   = req_addr[j*ADDR_W +: ADDR_W];
         end
      end
   end

   // Grant bookkeeping and registered ROM request
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_last        <= ID_W'(N_REQ - 1);
         r_owner       <= '0;
         r_owner_valid <= 1'b0;
         r_burst_cnt   <= '0;
         r_rom_en      <= 1'b0;
         r_rom_addr    <= '0;
         r_rom_id      <= '0;
      end else if (w_any) begin
         r_rom_en      <= 1'b1;
         r_rom_addr    <= w_addr;
         r_rom_id      <= w_sel;
         r_last        <= w_sel;
         r_owner       <= w_sel;
         r_owner_valid <= 1'b1;
         if (r_owner_valid && (w_sel == r_owner)) begin
            r_burst_cnt <= (r_burst_cnt == BURST_MAX) ? r_burst_cnt : r_burst_cnt + CNT_W'(1);
         end else begin
            r_burst_cnt <= '0;
         end
      end else begin
         r_rom_en      <= 1'b0;
         r_owner_valid <= 1'b0;
         r_burst_cnt   <= '0;
      end
   end

   // In-flight {valid, id} delay line matching the ROM latency
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pipe_v <= '0;
         for (int unsigned i = 0; i < ROM_LAT; i++) begin
            r_pipe_id[i] <= '0;
         end
      end else begin
         r_pipe_v[0]  <= r_rom_en;
         r_pipe_id[0] <= r_rom_id;
         for (int unsigned i = 1; i < ROM_LAT; i++) begin
            r_pipe_v[i]  <= r_pipe_v[i-1];
            r_pipe_id[i] <= r_pipe_id[i-1];
         end
      end
   end

   assign gnt      = w_gnt;
   assign rom_en   = r_rom_en;
   assign rom_addr = r_rom_addr;
   assign rd_valid = r_pipe_v[ROM_LAT-1];
   assign rd_id    = r_pipe_id[ROM_LAT-1];
   assign rd_data  = rd_valid ? rom_q : '0;
   assign busy     = r_rom_en | (|r_pipe_v);

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: two instances share stimulus, one with
// MAX_BURST=4/ROM_LAT=1 (A) and one with MAX_BURST=1/ROM_LAT=3 (B).
module tb_sprite_rom_arbiter;

   typedef struct packed {
      logic [1:0] id;
      logic [3:0] data;
   } exp_t;

   logic        clk;
   logic        reset_n;
   logic [2:0]  req;
   logic [35:0] req_addr;

   logic [2:0]  a_gnt, b_gnt;
   logic        a_rom_en, b_rom_en;
   logic [11:0] a_rom_addr, b_rom_addr;
   logic [3:0]  a_rom_q, b_rom_q;
   logic        a_rd_valid, b_rd_valid;
   logic [1:0]  a_rd_id, b_rd_id;
   logic [3:0]  a_rd_data, b_rd_data;
   logic        a_busy, b_busy;

   logic [3:0]  a_q_r;
   logic [3:0]  b_q_r [3];

   exp_t qa[$];
   exp_t qb[$];
   int   tests = 0;
   int   fails = 0;
   int   n     = 0;

   sprite_rom_arbiter #(.N_REQ(3), .ADDR_W(12), .DATA_W(4), .ROM_LAT(1), .MAX_BURST(4)) u_a (
      .vga_clk(clk), .reset_n(reset_n), .req(req), .req_addr(req_addr), .gnt(a_gnt),
      .rom_en(a_rom_en), .rom_addr(a_rom_addr), .rom_q(a_rom_q), .rd_valid(a_rd_valid),
      .rd_id(a_rd_id), .rd_data(a_rd_data), .busy(a_busy));

   sprite_rom_arbiter #(.N_REQ(3), .ADDR_W(12), .DATA_W(4), .ROM_LAT(3), .MAX_BURST(1)) u_b (
      .vga_clk(clk), .reset_n(reset_n), .req(req), .req_addr(req_addr), .gnt(b_gnt),
      .rom_en(b_rom_en), .rom_addr(b_rom_addr), .rom_q(b_rom_q), .rd_valid(b_rd_valid),
      .rd_id(b_rd_id), .rd_data(b_rd_data), .busy(b_busy));

   function automatic logic [3:0] rom_f(input logic [11:0] a);
      return a[3:0] ^ a[7:4] ^ a[11:8] ^ 4'h5;
   endfunction

   function automatic logic [1:0] oh2id(input logic [2:0] oh);
      return oh[2] ? 2'd2 : (oh[1] ? 2'd1 : 2'd0);
   endfunction

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ROM models with latency 1 (A) and 3 (B)
   always @(posedge clk) begin
      a_q_r    <= rom_f(a_rom_addr);
      b_q_r[0] <= rom_f(b_rom_addr);
      b_q_r[1] <= b_q_r[0];
      b_q_r[2] <= b_q_r[1];
   end
   assign a_rom_q = a_q_r;
   assign b_rom_q = b_q_r[2];

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitors
   always @(negedge clk) begin
      exp_t e;
      if (a_rd_valid) begin
         if (qa.size() == 0) begin
            tests++; fails++;
            $display("FAIL a_rd_unexpected: got rd_valid=1 id=%0d expected none (t=%0t)", a_rd_id, $time);
         end else begin
            e = qa.pop_front();
            chk("a_rd_id", a_rd_id, e.id);
            chk("a_rd_data", a_rd_data, e.data);
         end
      end else begin
         chk("a_rd_data_idle", a_rd_data, 0);
      end
      if (b_rd_valid) begin
         if (qb.size() == 0) begin
            tests++; fails++;
            $display("FAIL b_rd_unexpected: got rd_valid=1 id=%0d expected none (t=%0t)", b_rd_id, $time);
         end else begin
            e = qb.pop_front();
            chk("b_rd_id", b_rd_id, e.id);
            chk("b_rd_data", b_rd_data, e.data);
         end
      end else begin
         chk("b_rd_data_idle", b_rd_data, 0);
      end
   end

   // One cycle: drive req and per-requester addresses, check grants, queue expected reads
   task automatic step(input logic [2:0] r, input logic [2:0] ea, input logic [2:0] eb, input bit push);
      exp_t e;
      req = r;
      for (int i = 0; i < 3; i++) req_addr[i*12 +: 12] = 12'h123 + 12'(i * 256) + 12'(n);
      @(negedge clk);
      chk("gnt_a", a_gnt, ea);
      chk("gnt_b", b_gnt, eb);
      if (push && ea != 3'b000) begin
         e.id = oh2id(ea); e.data = rom_f(req_addr[e.id*12 +: 12]); qa.push_back(e);
      end
      if (push && eb != 3'b000) begin
         e.id = oh2id(eb); e.data = rom_f(req_addr[e.id*12 +: 12]); qb.push_back(e);
      end
      n++;
      @(posedge clk); #1;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_gnt_a"}, a_gnt, 0);        chk({tag, "_gnt_b"}, b_gnt, 0);
      chk({tag, "_rom_en_a"}, a_rom_en, 0);  chk({tag, "_rom_en_b"}, b_rom_en, 0);
      chk({tag, "_addr_a"}, a_rom_addr, 0);  chk({tag, "_addr_b"}, b_rom_addr, 0);
      chk({tag, "_rdv_a"}, a_rd_valid, 0);   chk({tag, "_rdv_b"}, b_rd_valid, 0);
      chk({tag, "_rdid_a"}, a_rd_id, 0);     chk({tag, "_rdid_b"}, b_rd_id, 0);
      chk({tag, "_busy_a"}, a_busy, 0);      chk({tag, "_busy_b"}, b_busy, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got no end of stimulus expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [2:0] ga2 [10];
      logic [2:0] gb2 [10];
      logic [2:0] ga4 [9];
      logic [2:0] gb4 [9];
      logic [2:0] r5  [7];
      logic [2:0] ga5 [7];
      logic [2:0] gb5 [7];
      ga2 = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b010};
      gb2 = '{3'b010, 3'b001, 3'b010, 3'b001, 3'b010, 3'b001, 3'b010, 3'b001, 3'b010, 3'b001};
      ga4 = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100, 3'b001};
      gb4 = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};
      r5  = '{3'b101, 3'b101, 3'b001, 3'b001, 3'b101, 3'b101, 3'b101};
      ga5 = '{3'b100, 3'b100, 3'b001, 3'b001, 3'b001, 3'b001, 3'b100};
      gb5 = '{3'b100, 3'b001, 3'b001, 3'b001, 3'b100, 3'b001, 3'b100};

      reset_n  = 1'b0;
      req      = '0;
      req_addr = '0;
      repeat (2) @(negedge clk);
      chk_idle("reset");
      reset_n = 1'b1;
      @(posedge clk); #1;

      // Single request from requester 0 at address 0x123; exact latency and busy
      step(3'b001, 3'b001, 3'b001, 1);
      req = '0; #1;
      chk("p1_rom_en_a", a_rom_en, 1);     chk("p1_rom_en_b", b_rom_en, 1);
      chk("p1_rom_addr_a", a_rom_addr, 12'h123);
      chk("p1_rom_addr_b", b_rom_addr, 12'h123);
      chk("p1_rdv_a_t1", a_rd_valid, 0);
      step(3'b000, 3'b000, 3'b000, 1);
      #1;
      chk("p1_rdv_a_t2", a_rd_valid, 1);   chk("p1_busy_a_t2", a_busy, 1);
      step(3'b000, 3'b000, 3'b000, 1);
      #1;
      chk("p1_busy_a_t3", a_busy, 0);      chk("p1_rdv_b_t3", b_rd_valid, 0);
      chk("p1_busy_b_t3", b_busy, 1);
      step(3'b000, 3'b000, 3'b000, 1);
      #1;
      chk("p1_rdv_b_t4", b_rd_valid, 1);   chk("p1_busy_b_t4", b_busy, 1);
      step(3'b000, 3'b000, 3'b000, 1);
      #1;
      chk("p1_busy_b_t5", b_busy, 0);

      // Two requesters held: bursts of 4 on A, strict alternation on B
      for (int i = 0; i < 10; i++) step(3'b011, ga2[i], gb2[i], 1);
      // Sole requester granted every cycle past the burst limit
      for (int i = 0; i < 6; i++) step(3'b001, 3'b001, 3'b001, 1);
      // All three requesting
      for (int i = 0; i < 9; i++) step(3'b111, ga4[i], gb4[i], 1);
      step(3'b000, 3'b000, 3'b000, 1);
      // Owner 2 drops after two grants; burst count restarts for requester 0
      for (int i = 0; i < 7; i++) step(r5[i], ga5[i], gb5[i], 1);
      for (int i = 0; i < 6; i++) step(3'b000, 3'b000, 3'b000, 1);

      // Reset in the middle of back-to-back grants: nothing may return
      step(3'b001, 3'b001, 3'b001, 0);
      chk("p6_gnt_a_t1", a_gnt, 3'b001);
      chk("p6_gnt_b_t1", b_gnt, 3'b001);
      reset_n = 1'b0;
      #1;
      chk_idle("midrst");
      req = '0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;
      step(3'b111, 3'b001, 3'b001, 1);
      for (int i = 0; i < 8; i++) step(3'b000, 3'b000, 3'b000, 1);

      chk("qa_drained", qa.size(), 0);
      chk("qb_drained", qb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
